// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Arbitrates two register-file write-back requesters onto a single
//   register-file write port. Each requester owns a one-entry skid buffer
//   (full flag, address, data). Grants are computed from the buffer full
//   flags. The winning buffer is then registered onto the write port on the
//   next clock edge. Uncontended latency is two edges: accept, then write.
//
// Configuration:
//   RF_WB_ARB_ROUND_ROBIN_EN
//     Defined:   contention is resolved round-robin. The winner of a
//                contended cycle gets the lowest priority on the next
//                contended cycle.
//     Undefined: fixed priority. req0 always wins contention and no
//                pointer state exists.
//
// Parameters:
//   ADR_WIDTH   register address width
//   DATA_WIDTH  register data width
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst_n          asynchronous active-low reset
//   flush_i        synchronous discard of all buffered, ungranted requests
//   reqN_valid_i   requester N write request
//   reqN_addr_i    requester N destination register
//   reqN_data_i    requester N write data
//   reqN_ready_o   requester N acceptance (combinational)
//   wen_o          register-file write enable
//   wa_o           register-file write address
//   write_data_o   register-file write data
//   grant_o        one-hot requester driving the current write (bit0 = req0)
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int ADR_WIDTH  = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,

    input  logic                  req0_valid_i,
    input  logic [ADR_WIDTH-1:0]  req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    output logic                  req0_ready_o,

    input  logic                  req1_valid_i,
    input  logic [ADR_WIDTH-1:0]  req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    output logic                  req1_ready_o,

    output logic                  wen_o,
    output logic [ADR_WIDTH-1:0]  wa_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic [1:0]            grant_o
);

    // Buffer state
    logic                  full0_q, full0_d;
    logic                  full1_q, full1_d;
    logic [ADR_WIDTH-1:0]  addr0_q, addr0_d;
    logic [ADR_WIDTH-1:0]  addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;

    // Write-port registers
    logic                  wen_q, wen_d;
    logic [1:0]            grant_q, grant_d;
    logic [ADR_WIDTH-1:0]  wa_q, wa_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;

    // Current-cycle arbitration and handshake
    logic grant0, grant1;
    logic ready0, ready1;
    logic accept0, accept1;

`ifdef RF_WB_ARB_ROUND_ROBIN_EN
    // rr_q = 0: req0 wins the next contended cycle; rr_q = 1: req1 wins.
    logic rr_q, rr_d;
    logic contended;
`endif

    // -----------------------------------------------------------------------
    // Grant: pure function of the full flags (and pointer, if present)
    // -----------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
        contended = full0_q && full1_q;
`endif
        if (full0_q && full1_q) begin
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
            if (rr_q) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b1;
            end
`else
            grant0 = 1'b1;
`endif
        end else if (full0_q) begin
            grant0 = 1'b1;
        end else if (full1_q) begin
            grant1 = 1'b1;
        end
    end

    // A buffer can take a new entry when empty, or when it is being drained
    // this very cycle (which gives the one-write-per-cycle streaming rate).
    // Reset is folded in only at the output so the flop next-state logic
    // never sees rst_n as a data input.
    assign ready0  = !flush_i && (!full0_q || grant0);
    assign ready1  = !flush_i && (!full1_q || grant1);
    assign accept0 = req0_valid_i && ready0;
    assign accept1 = req1_valid_i && ready1;

    assign req0_ready_o = ready0 && rst_n;
    assign req1_ready_o = ready1 && rst_n;

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        full0_d = full0_q;
        full1_d = full1_q;
        addr0_d = addr0_q;
        addr1_d = addr1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        wen_d   = 1'b0;
        grant_d = 2'b00;
        wa_d    = wa_q;
        wd_d    = wd_q;

        if (flush_i) begin
            // Discard everything buffered; any grant this cycle is void.
            full0_d = 1'b0;
            full1_d = 1'b0;
        end else begin
            // Drain first, then a same-edge refill overrides the clear.
            if (grant0) begin
                full0_d = 1'b0;
            end
            if (grant1) begin
                full1_d = 1'b0;
            end
            if (accept0) begin
                full0_d = 1'b1;
                addr0_d = req0_addr_i;
                data0_d = req0_data_i;
            end
            if (accept1) begin
                full1_d = 1'b1;
                addr1_d = req1_addr_i;
                data1_d = req1_data_i;
            end

            if (grant0) begin
                wen_d   = 1'b1;
                grant_d = 2'b01;
                wa_d    = addr0_q;
                wd_d    = data0_q;
            end else if (grant1) begin
                wen_d   = 1'b1;
                grant_d = 2'b10;
                wa_d    = addr1_q;
                wd_d    = data1_q;
            end
        end
    end

`ifdef RF_WB_ARB_ROUND_ROBIN_EN
    // Pointer only moves when both buffers competed and a write actually
    // issued; a flush leaves it untouched.
    always_comb begin
        rr_d = rr_q;
        if (contended && !flush_i) begin
            rr_d = grant0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Control and write-port registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            wen_q   <= 1'b0;
            grant_q <= 2'b00;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            full0_q <= full0_d;
            full1_q <= full1_d;
            wen_q   <= wen_d;
            grant_q <= grant_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    // Buffer payload is only meaningful while its full flag is set, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        addr0_q <= addr0_d;
        addr1_q <= addr1_d;
        data0_q <= data0_d;
        data1_q <= data1_d;
    end

    assign wen_o        = wen_q;
    assign grant_o      = grant_q;
    assign wa_o         = wa_q;
    assign write_data_o = wd_q;

endmodule
